// File: rtl/ft_control_if.sv
// Handshake bundle between the two lockstep cores, the result analyzer and ft_control.
// master: core/analyzer side driving commits and the compare result; slave: the controller.
interface ft_control_if #(
    parameter int NREGS = 32
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic          commit_a;
    logic          commit_b;
    logic          mismatch;
    logic          cmp_en;
    logic          halt_a;
    logic          halt_b;
    logic          recov_we;
    logic [AW-1:0] recov_addr;
    logic [7:0]    err_count;
    logic          fatal;

    modport master (
        output commit_a, commit_b, mismatch,
        input  cmp_en, halt_a, halt_b, recov_we, recov_addr, err_count, fatal
    );

    modport slave (
        input  commit_a, commit_b, mismatch,
        output cmp_en, halt_a, halt_b, recov_we, recov_addr, err_count, fatal
    );
endinterface

// File: rtl/ft_control.sv
// Dual-core lockstep fault-tolerance controller: pairs commits, compares, restores checkpoints (opt. FT_TIMEOUT_EN).
// Latency: commit pair -> cmp_en 1 cycle; matched compare -> halts released 1 cycle; all outputs registered.
// Backpressure: the leading core is halted until its partner commits; both halted through compare/recovery/fatal.
module ft_control #(
    parameter int NREGS     = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         reset,
    ft_control_if.slave  bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_A  = 3'd1;
    localparam logic [2:0] WAIT_B  = 3'd2;
    localparam logic [2:0] COMPARE = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;
    localparam logic [2:0] FATAL   = 3'd5;

    logic [2:0]    state, state_n;
    logic [RW-1:0] retry, retry_n;
    logic [7:0]    err_q, err_n;
    logic [AW-1:0] addr_q, addr_n;
    logic          fail;
    logic          cmp_en_q, halt_a_q, halt_b_q, recov_we_q, fatal_q;

`ifdef FT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          tmo;
    assign tmo = (tcnt == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_n = state;
        retry_n = retry;
        err_n   = err_q;
        addr_n  = addr_q;
        fail    = 1'b0;
`ifdef FT_TIMEOUT_EN
        tcnt_n  = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.commit_a && bus.commit_b) state_n = COMPARE;
                else if (bus.commit_a)            state_n = WAIT_B;
                else if (bus.commit_b)            state_n = WAIT_A;
            end
            WAIT_B: begin
                if (bus.commit_b) state_n = COMPARE;
`ifdef FT_TIMEOUT_EN
                else if (tmo)     fail    = 1'b1;
                else              tcnt_n  = tcnt + TW'(1);
`endif
            end
            WAIT_A: begin
                if (bus.commit_a) state_n = COMPARE;
`ifdef FT_TIMEOUT_EN
                else if (tmo)     fail    = 1'b1;
                else              tcnt_n  = tcnt + TW'(1);
`endif
            end
            COMPARE: begin
                if (bus.mismatch) begin
                    fail = 1'b1;
                end else begin
                    state_n = IDLE;
                    retry_n = '0;
                end
            end
            RECOVER: begin
                if (addr_q == AW'(NREGS - 1)) begin
                    state_n = IDLE;
                    addr_n  = '0;
                end else begin
                    addr_n  = addr_q + AW'(1);
                end
            end
            FATAL:   state_n = FATAL;
            default: state_n = IDLE;
        endcase

        // A timeout is treated exactly like a mismatching compare.
        if (fail) begin
            err_n   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            retry_n = (retry == RW'(MAX_RETRY + 1)) ? retry : retry + RW'(1);
            state_n = (retry_n > RW'(MAX_RETRY)) ? FATAL : RECOVER;
            addr_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            retry      <= '0;
            err_q      <= '0;
            addr_q     <= '0;
            cmp_en_q   <= 1'b0;
            halt_a_q   <= 1'b0;
            halt_b_q   <= 1'b0;
            recov_we_q <= 1'b0;
            fatal_q    <= 1'b0;
        end else begin
            state      <= state_n;
            retry      <= retry_n;
            err_q      <= err_n;
            addr_q     <= addr_n;
            cmp_en_q   <= (state_n == COMPARE);
            halt_a_q   <= (state_n == WAIT_B) || (state_n == COMPARE) ||
                          (state_n == RECOVER) || (state_n == FATAL);
            halt_b_q   <= (state_n == WAIT_A) || (state_n == COMPARE) ||
                          (state_n == RECOVER) || (state_n == FATAL);
            recov_we_q <= (state_n == RECOVER);
            fatal_q    <= (state_n == FATAL);
        end
    end

`ifdef FT_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt <= '0;
        else       tcnt <= tcnt_n;
    end
`endif

    assign bus.cmp_en     = cmp_en_q;
    assign bus.halt_a     = halt_a_q;
    assign bus.halt_b     = halt_b_q;
    assign bus.recov_we   = recov_we_q;
    assign bus.recov_addr = addr_q;
    assign bus.err_count  = err_q;
    assign bus.fatal      = fatal_q;
endmodule

// File: tb/tb_ft_control.sv
// Directed bench for ft_control: expected compare outcomes are queued at stimulus time and
// popped when the controller issues its cmp_en strobe.
module tb_ft_control;
    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ft_control_if #(.NREGS(NREGS)) bus ();
    ft_control #(.NREGS(NREGS), .MAX_RETRY(3), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [7:0] err;
        logic       recov;
        logic       fat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {bus.cmp_en, bus.halt_a, bus.halt_b, bus.recov_we, bus.fatal}, 5'b0);
        chk({tag, "_addr"}, bus.recov_addr, 0);
        chk({tag, "_err"}, bus.err_count, 0);
    endtask

    // Called at a negedge with the controller idle; returns at the negedge after the compare.
    task automatic pair(input logic mm, input logic [7:0] e_err, input logic e_rec, input logic e_fat);
        exp_t e;
        e.err = e_err; e.recov = e_rec; e.fat = e_fat;
        bus.commit_a = 1'b1; bus.commit_b = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.commit_a = 1'b0; bus.commit_b = 1'b0;
        chk("cmp_en_pulse", bus.cmp_en, 1);
        chk("cmp_halts", {bus.halt_a, bus.halt_b}, 2'b11);
        bus.mismatch = mm;
        @(negedge clk);
        bus.mismatch = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("err_count", bus.err_count, e.err);
            chk("recov_we_entry", bus.recov_we, e.recov);
            chk("fatal", bus.fatal, e.fat);
        end else begin
            chk("scoreboard_empty", exp_q.size(), 1);
        end
        chk("cmp_en_single", bus.cmp_en, 0);
    endtask

    task automatic check_recovery();
        for (int i = 0; i < NREGS; i++) begin
            chk("rec_we", bus.recov_we, 1);
            chk("rec_addr", bus.recov_addr, i);
            chk("rec_halts", {bus.halt_a, bus.halt_b}, 2'b11);
            @(negedge clk);
        end
        chk("rec_done_we", bus.recov_we, 0);
        chk("rec_done_halts", {bus.halt_a, bus.halt_b}, 2'b00);
    endtask

    // Leading core commits, the other follows 5 cycles later; lead re-commit is ignored.
    task automatic wait_test(input logic a_first);
        int hcnt = 0;
        if (a_first) bus.commit_a = 1'b1; else bus.commit_b = 1'b1;
        @(negedge clk);
        bus.commit_a = 1'b0; bus.commit_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (a_first && bus.halt_a && !bus.halt_b && !bus.cmp_en) hcnt++;
            if (!a_first && bus.halt_b && !bus.halt_a && !bus.cmp_en) hcnt++;
            if (a_first) bus.commit_a = (i == 2); else bus.commit_b = (i == 2);
            if (i == 5) begin
                if (a_first) bus.commit_b = 1'b1; else bus.commit_a = 1'b1;
            end
            @(negedge clk);
        end
        bus.commit_a = 1'b0; bus.commit_b = 1'b0;
        chk(a_first ? "waitb_halt_cycles" : "waita_halt_cycles", hcnt, 5);
        chk("wait_cmp_en", bus.cmp_en, 1);
        bus.mismatch = 1'b0;
        @(negedge clk);
        chk("wait_after_cmp_en", bus.cmp_en, 0);
        chk("wait_after_halts", {bus.halt_a, bus.halt_b}, 2'b00);
        chk("wait_after_recov", bus.recov_we, 0);
        chk("wait_after_err", bus.err_count, 0);
    endtask

    task automatic pair_quiet(input logic mm);
        bus.commit_a = 1'b1; bus.commit_b = 1'b1;
        @(negedge clk);
        bus.commit_a = 1'b0; bus.commit_b = 1'b0;
        bus.mismatch = mm;
        @(negedge clk);
        bus.mismatch = 1'b0;
        for (int k = 0; k < 40 && bus.halt_a; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        bus.commit_a = 1'b0; bus.commit_b = 1'b0; bus.mismatch = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Matched paired commit
        pair(1'b0, 8'd0, 1'b0, 1'b0);
        chk("pair_ok_halts", {bus.halt_a, bus.halt_b}, 2'b00);

        wait_test(1'b1);
        wait_test(1'b0);

`ifdef FT_TIMEOUT_EN
        bus.commit_a = 1'b1;
        @(negedge clk);
        bus.commit_a = 1'b0;
        seen = 0;
        for (int i = 1; i <= 64; i++) begin
            if (bus.cmp_en || bus.recov_we || !bus.halt_a) seen++;
            @(negedge clk);
        end
        chk("tmo_wait_clean", seen, 0);
        chk("tmo_recov_we", bus.recov_we, 1);
        chk("tmo_cmp_en", bus.cmp_en, 0);
        chk("tmo_err", bus.err_count, 1);
        check_recovery();
`else
        bus.commit_a = 1'b1;
        @(negedge clk);
        bus.commit_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cmp_en || bus.recov_we || !bus.halt_a) seen++;
            @(negedge clk);
        end
        chk("hold_wait_clean", seen, 0);
        chk("hold_err", bus.err_count, 0);
        bus.commit_b = 1'b1;
        @(negedge clk);
        bus.commit_b = 1'b0;
        chk("hold_cmp_en", bus.cmp_en, 1);
        @(negedge clk);
        chk("hold_release", {bus.halt_a, bus.halt_b}, 2'b00);
`endif

        // Single mismatch, then a match clears retry so three more mismatches stay recoverable
        do_reset();
        pair(1'b1, 8'd1, 1'b1, 1'b0);
        check_recovery();
        pair(1'b0, 8'd1, 1'b0, 1'b0);
        pair(1'b1, 8'd2, 1'b1, 1'b0);
        check_recovery();
        pair(1'b1, 8'd3, 1'b1, 1'b0);
        check_recovery();
        pair(1'b1, 8'd4, 1'b1, 1'b0);
        check_recovery();

        // Reset in the middle of a recovery
        do_reset();
        pair(1'b1, 8'd1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && bus.recov_addr != 5'd10; i++) @(negedge clk);
        chk("abort_reached_addr10", bus.recov_addr, 10);
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.recov_we || bus.cmp_en || bus.halt_a || bus.halt_b) seen++;
            @(negedge clk);
        end
        chk("abort_quiet", seen, 0);
        pair(1'b0, 8'd0, 1'b0, 1'b0);

        // Four consecutive mismatches: three recoveries then fatal
        pair(1'b1, 8'd1, 1'b1, 1'b0);
        check_recovery();
        pair(1'b1, 8'd2, 1'b1, 1'b0);
        check_recovery();
        pair(1'b1, 8'd3, 1'b1, 1'b0);
        check_recovery();
        pair(1'b1, 8'd4, 1'b0, 1'b1);
        chk("fatal_halts", {bus.halt_a, bus.halt_b}, 2'b11);
        bus.commit_a = 1'b1; bus.commit_b = 1'b1;
        @(negedge clk);
        bus.commit_a = 1'b0; bus.commit_b = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cmp_en || bus.recov_we || !bus.fatal) seen++;
            bus.commit_a = (i == 3);
            @(negedge clk);
        end
        bus.commit_a = 1'b0;
        chk("fatal_ignores_commits", seen, 0);
        chk("fatal_err", bus.err_count, 4);
        reset = 1'b1;
        #1;
        chk_all_zero("fatal_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // err_count saturates at 255
        for (int i = 0; i < 256; i++) begin
            pair_quiet(1'b1);
            pair_quiet(1'b0);
        end
        chk("err_saturate", bus.err_count, 255);
        chk("err_sat_fatal", bus.fatal, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ft_control.md
FT_CONTROL -- requirements
Module: ft_control

Interface
REQ-001 Parameter NREGS, default 32: number of architectural registers restored per recovery.
REQ-002 Parameter MAX_RETRY, default 3: consecutive failed comparisons tolerated before fatal.
REQ-003 Parameter TIMEOUT, default 64: cycles the trailing core may lag before a forced mismatch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 commit_a  input  1  core A commit strobe; result presented to analyzer.
REQ-007 commit_b  input  1  core B commit strobe.
REQ-008 mismatch  input  1  analyzer compare output; 1 = results differ, valid while cmp_en=1.
REQ-009 cmp_en  output  1  one-cycle strobe requesting analyzer comparison.
REQ-010 halt_a  output  1  stall core A.
REQ-011 halt_b  output  1  stall core B.
REQ-012 recov_we  output  1  checkpoint-restore write enable, both cores.
REQ-013 recov_addr  output  $clog2(NREGS)  register being restored.
REQ-014 err_count  output  8  total detected mismatches, saturating.
REQ-015 fatal  output  1  unrecoverable-fault flag, sticky.

Function
REQ-016 States IDLE, WAIT_A, WAIT_B, COMPARE, RECOVER, FATAL; all outputs registered.
REQ-017 IDLE: commit_a&commit_b -> COMPARE; commit_a only -> WAIT_B; commit_b only -> WAIT_A; else stay.
REQ-018 WAIT_B: halt_a=1; commit_b -> COMPARE; commit_a ignored (core halted).
REQ-019 WAIT_A: mirror of WAIT_B with halt_b=1.
REQ-020 COMPARE: lasts exactly 1 cycle; cmp_en=1, halt_a=halt_b=1; mismatch sampled this cycle.
REQ-021 COMPARE, mismatch=0 -> IDLE, retry counter cleared to 0.
REQ-022 COMPARE, mismatch=1 -> err_count+1 (saturate at 255); retry counter+1; if new retry count > MAX_RETRY -> FATAL else RECOVER.
REQ-023 RECOVER: halt_a=halt_b=1, recov_we=1, recov_addr steps 0..NREGS-1 one per cycle; exactly NREGS cycles, then IDLE with recov_we=0 and halts released.
REQ-024 Commit strobes arriving in RECOVER or FATAL are ignored.
REQ-025 FATAL: fatal=1, halt_a=halt_b=1, recov_we=0; exit only by reset.
REQ-026 Latency: commit pair to cmp_en = 1 cycle; matched compare to halts released = 1 cycle.
REQ-027 Retry counter width $clog2(MAX_RETRY+2); never wraps.

Reset
REQ-028 Reset asynchronously forces IDLE; cmp_en, halt_a, halt_b, recov_we, fatal = 0; recov_addr = 0; err_count = 0; retry = 0; timeout counter = 0.
REQ-029 Reset asserted mid-RECOVER or in FATAL aborts immediately; no further recov_we pulses after deassertion.

Configuration
REQ-030 Macro FT_TIMEOUT_EN: defined -> WAIT_A/WAIT_B count cycles; on reaching TIMEOUT without the trailing commit, transition as COMPARE with mismatch=1 (err_count+1, retry+1, RECOVER or FATAL), no cmp_en pulse.
REQ-031 FT_TIMEOUT_EN undefined -> no timeout counter; WAIT states hold indefinitely; TIMEOUT parameter unused.

Verification
REQ-032 Both commits same cycle, mismatch=0 -> cmp_en one cycle next cycle, err_count=0, back to IDLE, halts low.
REQ-033 commit_a at t, commit_b at t+5, mismatch=0 -> halt_a high 5 cycles, cmp_en single pulse, no recovery.
REQ-034 Paired commit, mismatch=1 -> err_count=1, recov_we high 32 cycles with recov_addr 0..31, then IDLE.
REQ-035 Four consecutive mismatching compares (MAX_RETRY=3) -> three recoveries, fourth enters FATAL, fatal=1, err_count=4; further commits ignored.
REQ-036 FT_TIMEOUT_EN defined, commit_a only, TIMEOUT=64 -> after 64 cycles in WAIT_B enter RECOVER, err_count=1, no cmp_en.
REQ-037 Reset asserted at recov_addr=10 -> all outputs zero immediately; IDLE after release.
